// File: rtl/alu_op_sequencer_if.sv
// Operation request / result handshake bundle between the control unit and alu_op_sequencer.
// master = control unit side, slave = sequencer side.
interface alu_op_sequencer_if;
  logic        op_valid;
  logic        op_ready;
  logic [4:0]  op_code;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] z_hi;
  logic [31:0] z_lo;
  logic        res_valid;
  logic        res_ready;
  logic        res_err;

  modport master (
    output op_valid, op_code, a_in, b_in, res_ready,
    input  op_ready, z_hi, z_lo, res_valid, res_err
  );

  modport slave (
    input  op_valid, op_code, a_in, b_in, res_ready,
    output op_ready, z_hi, z_lo, res_valid, res_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU front end: accepts one op, drives one-hot ALU controls for a per-class budget,
// captures the 64-bit result. Optional macro ALU_DIVZERO_TRAP_EN short-circuits DIV by zero.
module alu_op_sequencer #(
  parameter int SIMPLE_CYCLES = 1,
  parameter int MUL_CYCLES    = 4,
  parameter int DIV_CYCLES    = 8
) (
  input  logic                 clock,
  input  logic                 clear,
  alu_op_sequencer_if.slave    op_bus,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [13:0]          alu_ctl,
  input  logic [63:0]          alu_out_64,
  output logic                 busy
);

  localparam int MAX_MD     = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int MAX_BUDGET = (MAX_MD > SIMPLE_CYCLES) ? MAX_MD : SIMPLE_CYCLES;
  localparam int CW         = (MAX_BUDGET > 1) ? $clog2(MAX_BUDGET) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t        state_reg, state_next;
  logic [4:0]    op_reg;
  logic [31:0]   a_reg, b_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] budget_m1;
  logic [31:0]   z_hi_reg, z_lo_reg;
  logic          res_err_reg;
  logic          accept;
  logic          div_trap;
  logic          op_illegal;
  logic          exec_active;

  assign accept     = (state_reg == IDLE) && op_bus.op_valid;
  assign op_illegal = (op_reg > 5'd13);

`ifdef ALU_DIVZERO_TRAP_EN
  assign div_trap = (op_bus.op_code == 5'd12) && (op_bus.b_in == 32'd0);
`else
  assign div_trap = 1'b0;
`endif

  // Budget is chosen from the incoming opcode; illegal codes fall into the simple class.
  always_comb begin
    budget_m1 = CW'(SIMPLE_CYCLES - 1);
    case (op_bus.op_code)
      5'd11:   budget_m1 = CW'(MUL_CYCLES - 1);
      5'd12:   budget_m1 = CW'(DIV_CYCLES - 1);
      default: budget_m1 = CW'(SIMPLE_CYCLES - 1);
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (op_bus.op_valid) state_next = div_trap ? DONE : EXEC;
      EXEC:    if (cnt_reg == '0) state_next = DONE;
      DONE:    if (op_bus.res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    op_bus.op_ready  = 1'b0;
    op_bus.res_valid = 1'b0;
    busy             = 1'b1;
    exec_active      = 1'b0;
    case (state_reg)
      IDLE: begin
        op_bus.op_ready = 1'b1;
        busy            = 1'b0;
      end
      EXEC:    exec_active = 1'b1;
      DONE:    op_bus.res_valid = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      op_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      cnt_reg     <= '0;
      z_hi_reg    <= '0;
      z_lo_reg    <= '0;
      res_err_reg <= 1'b0;
    end else begin
      if (accept) begin
        op_reg  <= op_bus.op_code;
        a_reg   <= op_bus.a_in;
        b_reg   <= op_bus.b_in;
        cnt_reg <= budget_m1;
        if (div_trap) begin
          z_hi_reg    <= '0;
          z_lo_reg    <= '0;
          res_err_reg <= 1'b1;
        end
      end
      if (state_reg == EXEC) begin
        if (cnt_reg == '0) begin
          z_hi_reg    <= alu_out_64[63:32];
          z_lo_reg    <= alu_out_64[31:0];
          res_err_reg <= op_illegal;
        end else begin
          cnt_reg <= cnt_reg - CW'(1);
        end
      end
    end
  end

  // Illegal codes never match any bit, so the ALU sees no control and yields zero.
  for (genvar gi = 0; gi < 14; gi++) begin : g_ctl
    assign alu_ctl[gi] = exec_active && (op_reg == 5'(gi));
  end

  assign alu_a          = a_reg;
  assign alu_b          = b_reg;
  assign op_bus.z_hi    = z_hi_reg;
  assign op_bus.z_lo    = z_lo_reg;
  assign op_bus.res_err = res_err_reg;

endmodule
